regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-back controller: the writer side of the integer register file (2^ADDR_WIDTH x DATA_WIDTH, single write port: wen/waddr/wdata, write at posedge, combinational reads, x0 hardwired to 0).
- Arbitrates ALU and LSU result streams onto the single write port through a registered output stage.
- Keeps a busy scoreboard of destination registers with writes in flight; the issue stage queries it for RAW/WAW hazards.

Parameters:
ADDR_WIDTH, 5, register address width; 2^ADDR_WIDTH registers, scoreboard width.
DATA_WIDTH, 64, register data width.
CNT_WIDTH, 32, width of committed-write counter.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
iss_valid  input  1  issue stage dispatches an instruction writing iss_rd.
iss_rd  input  ADDR_WIDTH  destination of issuing instruction.
iss_ready  output  1  issue may complete this cycle (no WAW on iss_rd).
rs1_addr  input  ADDR_WIDTH  hazard query 1.
rs2_addr  input  ADDR_WIDTH  hazard query 2.
rs1_busy  output  1  rs1_addr has a write pending.
rs2_busy  output  1  rs2_addr has a write pending.
alu_valid  input  1  ALU result valid.
alu_ready  output  1  ALU result accepted when alu_valid & alu_ready.
alu_rd  input  ADDR_WIDTH  ALU result destination.
alu_data  input  DATA_WIDTH  ALU result.
lsu_valid  input  1  load result valid.
lsu_ready  output  1  load result accepted when lsu_valid & lsu_ready.
lsu_rd  input  ADDR_WIDTH  load destination.
lsu_data  input  DATA_WIDTH  load data.
rf_wen  output  1  register-file write enable.
rf_waddr  output  ADDR_WIDTH  register-file write address.
rf_wdata  output  DATA_WIDTH  register-file write data.
wb_count  output  CNT_WIDTH  number of committed non-x0 writes.

Behaviour:
- Reset (rst=1 at posedge): busy vector cleared to 0; rf_wen=0, rf_waddr=0, rf_wdata=0, wb_count=0. A reset mid-operation discards any pending write; no write is performed in the cycle after the reset edge.
- Handshake: valid/ready. A source holds valid, rd and data stable until accepted. A transfer occurs when valid & ready are both high at the posedge.
- Arbitration: fixed priority, LSU over ALU. lsu_ready=1 always. alu_ready = ~lsu_valid. Both ready signals are combinational.
- Output stage: a single register, always drains because the register file never stalls.
  - On an accepted transfer with rd!=0: next cycle rf_wen=1, rf_waddr=rd, rf_wdata=data. Latency is 1 cycle from handshake to rf_wen, so the data is readable from the register file 2 edges after the handshake.
  - On an accepted transfer with rd=0: accepted, rf_wen=0, no count.
  - No transfer: rf_wen=0. rf_waddr and rf_wdata hold their previous values.
- Scoreboard busy[0..2^ADDR_WIDTH-1]:
  - Set: at the edge where iss_valid & iss_ready & iss_rd!=0.
  - Clear: at the edge where rf_wen=1 for rf_waddr (same edge the register file writes).
  - Set and clear of the same address at the same edge: set wins (busy stays 1).
  - busy[0] is constant 0.
- Queries (combinational):
  - rs1_busy = busy[rs1_addr]; rs2_busy = busy[rs2_addr]; x0 always reports 0.
  - No bypass: a register being written this cycle still reports busy.
  - iss_ready = ~busy[iss_rd]. Conservative: stays 0 in the cycle busy clears. iss_rd=0 always ready.
- wb_count increments by 1 at every edge with rf_wen=1; wraps modulo 2^CNT_WIDTH. Writes to x0 never counted.
- Write-back of an rd that is not busy (unscoreboarded): still written and counted; busy stays 0.

Test Plan:
- Reset: assert rst 2 cycles with traffic present -> rf_wen=0, wb_count=0, rs1_busy=0 for rs1_addr=5, iss_ready=1 for iss_rd=5.
- Scoreboard round trip: iss rd=5 at cycle 0 -> rs1_busy(5)=1 from cycle 1. ALU valid rd=5, data=0xDEAD at cycle 3 -> rf_wen=1, waddr=5, wdata=0xDEAD at cycle 4. busy(5)=0 from cycle 5. wb_count=1.
- Contention: alu(rd=3, 0x11) and lsu(rd=4, 0x22) valid together -> cycle n+1 writes x4=0x22 with alu_ready=0. Cycle n+2 writes x3=0x11. wb_count +2.
- x0: alu rd=0, data=0xFF accepted -> alu_ready=1, rf_wen stays 0, wb_count unchanged. iss rd=0 -> busy(0) stays 0.
- WAW / set-wins: x7 busy -> iss_ready=0 for iss_rd=7. Issue rd=7 at the same edge as the rf write to x7 -> busy(7)=1 afterwards.
- Counter wrap and mid-op reset: preset via CNT_WIDTH=4, 16 writes -> wb_count=0. Reset asserted the cycle after a handshake -> no rf_wen in the next cycle.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the integer register file.
// Arbitrates the LSU and ALU result streams onto the single write port through
// one registered output stage. LSU has fixed priority over ALU. Also keeps a
// busy scoreboard of destination registers that the issue stage uses to detect
// RAW and WAW hazards.
module regfile_wb_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    logic [NREGS-1:0]      busy_q, busy_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    wb_req_t req;
    logic    req_fire;
    logic    iss_fire;

    // The register file never stalls, so the LSU can always be taken. The ALU
    // waits out any cycle in which the LSU presents a result.
    assign lsu_ready = 1'b1;
    assign alu_ready = ~lsu_valid;

    // No bypass: a register being written this cycle still reads as busy.
    // busy_q[0] is held at 0, so x0 always reports free.
    assign rs1_busy  = busy_q[rs1_addr];
    assign rs2_busy  = busy_q[rs2_addr];
    assign iss_ready = ~busy_q[iss_rd];
    assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_count = cnt_q;

    // Pick the winning source for this cycle's write-back transfer.
    always_comb begin
        req_fire = lsu_valid | alu_valid;
        if (lsu_valid) begin
            req.rd   = lsu_rd;
            req.data = lsu_data;
        end else begin
            req.rd   = alu_rd;
            req.data = alu_data;
        end
    end

    // Next state of output stage, scoreboard and commit counter.
    always_comb begin
        rf_wen_d   = req_fire & (req.rd != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (rf_wen_d) begin
            rf_waddr_d = req.rd;
            rf_wdata_d = req.data;
        end

        // Clear on the edge the register file is written; a same-edge issue
        // of that address is applied afterwards so the set wins.
        busy_d = busy_q;
        if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
        if (iss_fire) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;

        cnt_d = cnt_q + CNT_WIDTH'(rf_wen_q);
    end

    // State registers; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of in-flight registers and the
// write-back pipe. Counter width is reduced to 4 so wrap-around is reachable.
module tb_regfile_wb_ctrl;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic          rs1_busy, rs2_busy;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid, lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [CW-1:0] wb_count;

    regfile_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: set of registers with a write in flight, the write
    // the register file will see this cycle, and the committed-write count.
    bit            m_busy [32];
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_wen = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
    endtask

    // Check all outputs against the model for the current inputs, then
    // advance one clock and update the model from what was presented.
    task automatic tick();
        bit            go_iss, win;
        logic [AW-1:0] w_rd;
        logic [DW-1:0] w_data;
        #1;
        chk("lsu_ready", lsu_ready, 1);
        chk("alu_ready", alu_ready, !lsu_valid);
        chk("iss_ready", iss_ready, (iss_rd == 0) || !m_busy[iss_rd]);
        chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
        chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("wb_count", wb_count, m_cnt);

        go_iss = iss_valid && iss_rd != 0 && !m_busy[iss_rd];
        win    = lsu_valid || alu_valid;
        w_rd   = lsu_valid ? lsu_rd : alu_rd;
        w_data = lsu_valid ? lsu_data : alu_data;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (m_wen) begin
                m_busy[m_waddr] = 0;
                m_cnt = (m_cnt + 1) % 16;
            end
            if (go_iss) m_busy[iss_rd] = 1;
            m_wen = win && w_rd != 0;
            if (m_wen) begin
                m_waddr = w_rd;
                m_wdata = w_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        iss_valid = 0; alu_valid = 0; lsu_valid = 0;
    endtask

    bit alu_hold;

    initial begin
        // Reset for two cycles with traffic present.
        rst = 1; iss_valid = 1; iss_rd = 5; rs1_addr = 5; rs2_addr = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
        lsu_valid = 1; lsu_rd = 6; lsu_data = 64'h5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 0; idle(); iss_rd = 5; rs1_addr = 5;
        #1;
        chk("rst_wen", rf_wen, 0);
        chk("rst_cnt", wb_count, 0);
        chk("rst_rs1busy", rs1_busy, 0);
        chk("rst_issready", iss_ready, 1);

        // Scoreboard round trip on x5.
        iss_valid = 1; iss_rd = 5;
        tick();
        iss_valid = 0;
        #1 chk("rt_busy_c1", rs1_busy, 1);
        tick(); tick();
        alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD;
        tick();
        alu_valid = 0;
        chk("rt_wen", rf_wen, 1);
        chk("rt_waddr", rf_waddr, 5);
        chk("rt_wdata", rf_wdata, 64'hDEAD);
        #1 chk("rt_nobypass", rs1_busy, 1);
        tick();
        #1 chk("rt_busy_c5", rs1_busy, 0);
        chk("rt_cnt", wb_count, 1);

        // LSU beats ALU; ALU holds and goes next.
        alu_valid = 1; alu_rd = 3; alu_data = 64'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h22;
        #1 chk("ct_alu_ready", alu_ready, 0);
        tick();
        lsu_valid = 0;
        chk("ct_waddr1", rf_waddr, 4);
        chk("ct_wdata1", rf_wdata, 64'h22);
        #1 chk("ct_alu_ready2", alu_ready, 1);
        tick();
        chk("ct_waddr2", rf_waddr, 3);
        chk("ct_wdata2", rf_wdata, 64'h11);

        // Writes to x0 are accepted but not performed or counted.
        alu_rd = 0; alu_data = 64'hFF;
        #1 chk("x0_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        chk("x0_wen", rf_wen, 0);
        chk("x0_cnt", wb_count, 3);
        iss_valid = 1; iss_rd = 0; rs1_addr = 0;
        tick();
        iss_valid = 0;
        #1 chk("x0_busy", rs1_busy, 0);
        chk("x0_iss_ready", iss_ready, 1);
        chk("x0_cnt2", wb_count, 3);

        // WAW block, then set-wins on an unscoreboarded write to x7.
        iss_valid = 1; iss_rd = 7;
        tick();
        iss_valid = 0;
        #1 chk("waw_ready", iss_ready, 0);
        alu_valid = 1; alu_rd = 7; alu_data = 64'h70;
        tick();
        alu_valid = 0;
        #1 chk("waw_conservative", iss_ready, 0);
        tick();
        #1 chk("waw_cleared", iss_ready, 1);
        alu_valid = 1; alu_data = 64'h71;
        tick();
        alu_valid = 0;
        chk("sw_wen", rf_wen, 1);
        chk("sw_waddr", rf_waddr, 7);
        iss_valid = 1;
        tick();
        iss_valid = 0; rs1_addr = 7;
        #1 chk("sw_busy", rs1_busy, 1);
        alu_valid = 1; alu_data = 64'h72;
        tick();
        alu_valid = 0;
        tick(); tick();

        // Counter wrap after 16 committed writes.
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 16; i++) begin
            lsu_valid = 1; lsu_rd = AW'(1 + i); lsu_data = DW'(i);
            tick();
        end
        lsu_valid = 0;
        chk("wrap_cnt15", wb_count, 15);
        tick();
        chk("wrap_cnt0", wb_count, 0);

        // Reset right after a handshake drops the pending write.
        lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h99;
        tick();
        lsu_valid = 0; rst = 1;
        tick();
        rst = 0;
        chk("midrst_wen", rf_wen, 0);
        chk("midrst_waddr", rf_waddr, 0);
        tick();
        chk("midrst_wen2", rf_wen, 0);

        // Randomized traffic; ALU holds its request until accepted.
        alu_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(199) == 0);
            iss_valid = 1'($urandom_range(1));
            iss_rd    = AW'($urandom_range(31));
            rs1_addr  = AW'($urandom_range(31));
            rs2_addr  = AW'($urandom_range(31));
            if (!alu_hold) begin
                alu_valid = ($urandom_range(2) != 0);
                alu_rd    = AW'($urandom_range(31));
                alu_data  = {$urandom(), $urandom()};
            end
            lsu_valid = ($urandom_range(2) == 0);
            lsu_rd    = AW'($urandom_range(31));
            lsu_data  = {$urandom(), $urandom()};
            alu_hold  = alu_valid && lsu_valid;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
